// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs instruction field bundles into 16-bit words and
// streams them into instruction RAM at consecutive addresses.
module instr_encoder_loader #(parameter int ADDR_W = 8) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        rn,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [1:0]        shift,
  input  logic [15:0]       imm,
  output logic              mem_write,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_illegal,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state;
  logic [15:0] word;
  logic illegal, bad_imm, imm8_ok, imm5_ok, wr_done, last_pending, accept;
  assign imm8_ok = imm == {{8{imm[7]}}, imm[7:0]};
  assign imm5_ok = imm == {{11{imm[4]}}, imm[4:0]};
  always_comb begin
    word = {opcode, op, 11'b0};
    illegal = 1'b0;
    bad_imm = 1'b0;
    case ({opcode, op})
      5'b110_10: begin word[10:0] = {rn, imm[7:0]}; bad_imm = !imm8_ok; end
      5'b110_00, 5'b101_11: word[10:0] = {3'b000, rd, shift, rm};
      5'b101_00, 5'b101_10: word[10:0] = {rn, rd, shift, rm};
      5'b101_01: word[10:0] = {rn, 3'b000, shift, rm};
      5'b011_00, 5'b100_00: begin word[10:0] = {rn, rd, imm[4:0]}; bad_imm = !imm5_ok; end
      5'b111_00: ;
      default: illegal = 1'b1;
    endcase
  end
  // A pending HALT or a pending write to the top address is the final word of the load.
  assign last_pending = mem_write && (mem_din[15:11] == 5'b111_00 || &mem_addr);
  assign wr_done = mem_write && mem_ready;
  assign in_ready = state == LOAD && (!mem_write || mem_ready) && !last_pending;
  assign accept = in_valid && in_ready;
  assign busy = state == LOAD;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      err_range <= 1'b0;
      err_illegal <= 1'b0;
      word_count <= '0;
    end else if (state != LOAD) begin
      if (start) begin
        state <= LOAD;
        mem_addr <= start_addr;
        word_count <= '0;
        err_range <= 1'b0;
        err_illegal <= 1'b0;
      end
    end else begin
      if (wr_done) begin
        word_count <= word_count + 1'b1;
        if (last_pending) state <= DONE;
        else mem_addr <= mem_addr + 1'b1;
      end
      if (accept && !illegal && !bad_imm) begin
        mem_write <= 1'b1;
        mem_din <= word;
      end else if (wr_done) mem_write <= 1'b0;
      if (accept) begin
        err_illegal <= err_illegal | illegal;
        err_range <= err_range | bad_imm;
      end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized and directed checks of the encoder/loader
// against an arithmetic model of the instruction word format.
module tb_instr_encoder_loader;
  logic clk = 0, reset_n = 1, start = 0, start2 = 0, in_valid = 0, mem_ready = 1;
  logic [7:0] start_addr = 0;
  logic [1:0] start_addr2 = 0;
  logic [2:0] opcode = 0, rn = 0, rd = 0, rm = 0;
  logic [1:0] op = 0, shift = 0;
  logic [15:0] imm = 0;
  logic in_ready, mem_write, busy, done, err_range, err_illegal;
  logic [7:0] mem_addr;
  logic [15:0] mem_din;
  logic [8:0] word_count;
  logic in_ready2, mem_write2, busy2, done2, err_range2, err_illegal2;
  logic [1:0] mem_addr2;
  logic [15:0] mem_din2;
  logic [2:0] word_count2;
  int passed = 0, total = 0;
  int m_addr, m_cnt;
  bit m_er, m_ei;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .op(op),
    .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
    .mem_write(mem_write), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done), .err_range(err_range), .err_illegal(err_illegal),
    .word_count(word_count));

  instr_encoder_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .start_addr(start_addr2),
    .in_valid(in_valid), .in_ready(in_ready2), .opcode(opcode), .op(op),
    .rn(rn), .rd(rd), .rm(rm), .shift(shift), .imm(imm),
    .mem_write(mem_write2), .mem_ready(mem_ready), .mem_addr(mem_addr2), .mem_din(mem_din2),
    .busy(busy2), .done(done2), .err_range(err_range2), .err_illegal(err_illegal2),
    .word_count(word_count2));

  // kind: 0 legal, 1 immediate out of range, 2 unsupported code
  function automatic void model(input int oc, o, n, d, m, sh, im, output int w, output int kind);
    int s = im > 32767 ? im - 65536 : im;
    int c = oc * 4 + o;
    w = oc * 8192 + o * 2048;
    kind = 0;
    if (c == 26) begin w += n * 256 + (s & 255); kind = (s < -128 || s > 127) ? 1 : 0; end
    else if (c == 24 || c == 23) w += d * 32 + sh * 8 + m;
    else if (c == 20 || c == 22) w += n * 256 + d * 32 + sh * 8 + m;
    else if (c == 21) w += n * 256 + sh * 8 + m;
    else if (c == 12 || c == 16) begin w += n * 256 + d * 32 + (s & 31); kind = (s < -16 || s > 15) ? 1 : 0; end
    else if (c != 28) kind = 2;
  endfunction

  task automatic xfer(input int oc, o, n, d, m, sh, im, output int cyc);
    opcode = 3'(oc); op = 2'(o); rn = 3'(n); rd = 3'(d); rm = 3'(m); shift = 2'(sh); imm = 16'(im);
    in_valid = 1; cyc = -1;
    for (int i = 1; i <= 20 && cyc < 0; i++) begin
      #1; if (in_ready) cyc = i;
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic do_start(input int a);
    start_addr = 8'(a); start = 1;
    @(negedge clk);
    start = 0; m_addr = a; m_cnt = 0; m_er = 0; m_ei = 0;
  endtask

  task automatic test_reset;
    total++; if (mem_write !== 1'b0) $display("FAIL rst_write got %b exp 0", mem_write); else passed++;
    total++; if (mem_addr !== 8'h00) $display("FAIL rst_addr got %h exp 00", mem_addr); else passed++;
    total++; if (mem_din !== 16'h0000) $display("FAIL rst_din got %h exp 0000", mem_din); else passed++;
    total++; if ({in_ready, busy, done, err_range, err_illegal} !== 5'b0) $display("FAIL rst_flags got %b exp 00000", {in_ready, busy, done, err_range, err_illegal}); else passed++;
    total++; if (word_count !== 9'd0) $display("FAIL rst_count got %0d exp 0", word_count); else passed++;
  endtask

  task automatic test_wrap;
    int w, k;
    start_addr2 = 2'd3; start2 = 1;
    @(negedge clk);
    start2 = 0;
    opcode = 3'd6; op = 2'd2; rn = 3'd1; imm = 16'd5; in_valid = 1;
    model(6, 2, 1, 0, 0, 0, 5, w, k);
    #1;
    total++; if (in_ready2 !== 1'b1) $display("FAIL wrap_ready0 got %b exp 1", in_ready2); else passed++;
    @(negedge clk);
    total++; if ({mem_write2, mem_addr2, mem_din2} !== {1'b1, 2'd3, 16'(w)}) $display("FAIL wrap_write got %b/%h/%h exp 1/3/%h", mem_write2, mem_addr2, mem_din2, 16'(w)); else passed++;
    total++; if (in_ready2 !== 1'b0) $display("FAIL wrap_ready1 got %b exp 0", in_ready2); else passed++;
    imm = 16'd7;
    @(negedge clk);
    total++; if ({done2, mem_write2, mem_addr2, word_count2} !== {1'b1, 1'b0, 2'd3, 3'd1}) $display("FAIL wrap_done got %b/%b/%h/%0d exp 1/0/3/1", done2, mem_write2, mem_addr2, word_count2); else passed++;
    @(negedge clk);
    total++; if ({mem_write2, in_ready2, word_count2} !== {1'b0, 1'b0, 3'd1}) $display("FAIL wrap_noaccept got %b/%b/%0d exp 0/0/1", mem_write2, in_ready2, word_count2); else passed++;
    in_valid = 0;
  endtask

  task automatic test_basic;
    int w, k, cyc;
    do_start(16);
    total++; if ({busy, mem_addr, word_count} !== {1'b1, 8'h10, 9'd0}) $display("FAIL start got %b/%h/%0d exp 1/10/0", busy, mem_addr, word_count); else passed++;
    xfer(6, 2, 3, 0, 0, 0, 'hFFFB, cyc);
    model(6, 2, 3, 0, 0, 0, 'hFFFB, w, k);
    total++; if (cyc !== 1) $display("FAIL mov_accept got %0d exp 1", cyc); else passed++;
    total++; if ({mem_write, mem_addr, mem_din} !== {1'b1, 8'h10, 16'(w)}) $display("FAIL mov_write got %b/%h/%h exp 1/10/%h", mem_write, mem_addr, mem_din, 16'(w)); else passed++;
    @(negedge clk);
    total++; if ({mem_write, mem_addr, word_count} !== {1'b0, 8'h11, 9'd1}) $display("FAIL mov_done got %b/%h/%0d exp 0/11/1", mem_write, mem_addr, word_count); else passed++;
    m_addr = 17; m_cnt = 1;
  endtask

  task automatic test_back_to_back;
    int w1, w2, k, cyc;
    model(5, 0, 2, 1, 4, 1, 0, w1, k);
    model(3, 0, 6, 5, 0, 3, 'hFFF0, w2, k);
    xfer(5, 0, 2, 1, 4, 1, 0, cyc);
    total++; if ({mem_write, mem_addr, mem_din} !== {1'b1, 8'(m_addr), 16'(w1)}) $display("FAIL b2b_add got %b/%h/%h exp 1/%h/%h", mem_write, mem_addr, mem_din, 8'(m_addr), 16'(w1)); else passed++;
    xfer(3, 0, 6, 5, 0, 3, 'hFFF0, cyc);
    total++; if (cyc !== 1) $display("FAIL b2b_accept got %0d exp 1", cyc); else passed++;
    total++; if ({mem_write, mem_addr, mem_din, word_count} !== {1'b1, 8'(m_addr + 1), 16'(w2), 9'(m_cnt + 1)}) $display("FAIL b2b_ldr got %b/%h/%h/%0d exp 1/%h/%h/%0d", mem_write, mem_addr, mem_din, word_count, 8'(m_addr + 1), 16'(w2), m_cnt + 1); else passed++;
    @(negedge clk);
    total++; if (word_count !== 9'(m_cnt + 2)) $display("FAIL b2b_count got %0d exp %0d", word_count, m_cnt + 2); else passed++;
    m_addr += 2; m_cnt += 2;
  endtask

  task automatic test_range;
    int w, k, cyc;
    xfer(4, 0, 1, 2, 0, 0, 16, cyc);
    total++; if ({err_range, mem_write, mem_addr} !== {1'b1, 1'b0, 8'(m_addr)}) $display("FAIL str16 got %b/%b/%h exp 1/0/%h", err_range, mem_write, mem_addr, 8'(m_addr)); else passed++;
    xfer(4, 0, 1, 2, 0, 0, 15, cyc);
    model(4, 0, 1, 2, 0, 0, 15, w, k);
    total++; if ({mem_write, mem_addr, mem_din} !== {1'b1, 8'(m_addr), 16'(w)}) $display("FAIL str15 got %b/%h/%h exp 1/%h/%h", mem_write, mem_addr, mem_din, 8'(m_addr), 16'(w)); else passed++;
    m_addr++; m_cnt++;
    xfer(7, 1, 0, 0, 0, 0, 0, cyc);
    total++; if ({err_illegal, mem_write, word_count} !== {1'b1, 1'b0, 9'(m_cnt)}) $display("FAIL illegal got %b/%b/%0d exp 1/0/%0d", err_illegal, mem_write, word_count, m_cnt); else passed++;
    m_er = 1; m_ei = 1;
  endtask

  task automatic test_stall;
    int w, k, cyc;
    xfer(6, 0, 0, 3, 2, 2, 0, cyc);
    model(6, 0, 0, 3, 2, 2, 0, w, k);
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({mem_write, mem_addr, mem_din, in_ready} !== {1'b1, 8'(m_addr), 16'(w), 1'b0}) $display("FAIL stall%0d got %b/%h/%h/%b exp 1/%h/%h/0", i, mem_write, mem_addr, mem_din, in_ready, 8'(m_addr), 16'(w)); else passed++;
    end
    mem_ready = 1;
    @(negedge clk);
    total++; if ({mem_write, mem_addr, word_count} !== {1'b0, 8'(m_addr + 1), 9'(m_cnt + 1)}) $display("FAIL stall_done got %b/%h/%0d exp 0/%h/%0d", mem_write, mem_addr, word_count, 8'(m_addr + 1), m_cnt + 1); else passed++;
    m_addr++; m_cnt++;
  endtask

  task automatic test_halt;
    int w, k, cyc;
    xfer(7, 0, 0, 0, 0, 0, 0, cyc);
    model(7, 0, 0, 0, 0, 0, 0, w, k);
    total++; if ({mem_write, mem_din, in_ready} !== {1'b1, 16'(w), 1'b0}) $display("FAIL halt_write got %b/%h/%b exp 1/%h/0", mem_write, mem_din, in_ready, 16'(w)); else passed++;
    @(negedge clk);
    total++; if ({done, busy, in_ready, word_count, mem_addr} !== {1'b1, 1'b0, 1'b0, 9'(m_cnt + 1), 8'(m_addr)}) $display("FAIL halt_done got %b/%b/%b/%0d/%h exp 1/0/0/%0d/%h", done, busy, in_ready, word_count, mem_addr, m_cnt + 1, 8'(m_addr)); else passed++;
    do_start(64);
    total++; if ({busy, word_count, err_range, err_illegal, mem_addr} !== {1'b1, 9'd0, 1'b0, 1'b0, 8'h40}) $display("FAIL restart got %b/%0d/%b/%b/%h exp 1/0/0/0/40", busy, word_count, err_range, err_illegal, mem_addr); else passed++;
  endtask

  task automatic test_random;
    int codes[8] = '{26, 24, 20, 22, 21, 23, 12, 16};
    int c, im, w, k, cyc;
    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 31)) : codes[$urandom_range(0, 7)];
      if (c == 28) c = 29;
      im = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, 65535)) : ((int'($urandom_range(0, 300)) - 150) & 65535);
      if ($urandom_range(0, 1) == 1) im = (int'($urandom_range(0, 40)) - 20) & 65535;
      model(c / 4, c % 4, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3), im, w, k);
      xfer(c / 4, c % 4, rn, rd, rm, shift, im, cyc);
      model(c / 4, c % 4, rn, rd, rm, shift, im, w, k);
      total++; if (cyc !== 1) $display("FAIL rnd%0d_accept got %0d exp 1", i, cyc); else passed++;
      if (k == 0) begin
        total++; if ({mem_write, mem_addr, mem_din, word_count} !== {1'b1, 8'(m_addr), 16'(w), 9'(m_cnt)}) $display("FAIL rnd%0d_write got %b/%h/%h/%0d exp 1/%h/%h/%0d", i, mem_write, mem_addr, mem_din, word_count, 8'(m_addr), 16'(w), m_cnt); else passed++;
        m_addr++; m_cnt++;
      end else begin
        m_er |= k == 1; m_ei |= k == 2;
        total++; if (mem_write !== 1'b0) $display("FAIL rnd%0d_nowrite got %b exp 0", i, mem_write); else passed++;
      end
      total++; if ({err_range, err_illegal} !== {m_er, m_ei}) $display("FAIL rnd%0d_err got %b%b exp %b%b", i, err_range, err_illegal, m_er, m_ei); else passed++;
    end
    @(negedge clk);
    total++; if ({word_count, mem_addr} !== {9'(m_cnt), 8'(m_addr)}) $display("FAIL rnd_final got %0d/%h exp %0d/%h", word_count, mem_addr, m_cnt, 8'(m_addr)); else passed++;
  endtask

  task automatic test_async_reset;
    int cyc;
    xfer(6, 2, 2, 0, 0, 0, 9, cyc);
    mem_ready = 0;
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    total++; if ({mem_write, busy, in_ready, mem_addr, mem_din, word_count} !== {3'b000, 8'h00, 16'h0000, 9'd0}) $display("FAIL async_rst got %b/%b/%b/%h/%h/%0d exp 0/0/0/00/0000/0", mem_write, busy, in_ready, mem_addr, mem_din, word_count); else passed++;
    #1 reset_n = 1;
    mem_ready = 1;
  endtask

  initial begin
    #1 reset_n = 0;
    #2 test_reset;
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    test_wrap;
    test_basic;
    test_back_to_back;
    test_range;
    test_stall;
    test_halt;
    test_random;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Reverse of the instruction decoder. Takes instruction fields from a host or testbench over a valid/ready handshake and range-checks the immediates. Packs each instruction into the 16-bit word format the decoder consumes, then writes the words into instruction memory at consecutive addresses. Sits between the program-load host and the instruction RAM write port, ahead of the CPU.

Parameters:
ADDR_W, 8, instruction memory address width; memory depth is 2**ADDR_W words.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; in IDLE loads start_addr and enters LOAD
start_addr  input  ADDR_W  first write address
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle this cycle
opcode  input  3  instruction class, word bits [15:13]
op  input  2  sub-op, word bits [12:11]
rn  input  3  Rn field
rd  input  3  Rd field
rm  input  3  Rm field
shift  input  2  shift code
imm  input  16  signed two's-complement immediate value
mem_write  output  1  write strobe, one word per cycle when mem_ready=1
mem_ready  input  1  memory accepts the write this cycle
mem_addr  output  ADDR_W  write address
mem_din  output  16  packed instruction word
busy  output  1  state==LOAD
done  output  1  state==DONE
err_range  output  1  sticky: a dropped bundle had an out-of-range immediate
err_illegal  output  1  sticky: a dropped bundle had an unsupported {opcode,op}
word_count  output  ADDR_W+1  number of words actually written since start

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_write=0; mem_addr=0; mem_din=0; err flags=0; word_count=0; in_ready=0.
- States:
  - IDLE: start -> LOAD; addr<=start_addr; word_count<=0; errors cleared.
  - LOAD: accepts bundles. Moves to DONE after HALT is written, or after the word at address 2**ADDR_W-1 is written.
  - DONE: holds until start; start -> LOAD with a fresh start_addr.
- start outside IDLE/DONE is ignored.
- in_ready = (state==LOAD) && (!mem_write || mem_ready) && !halt_pending. A transfer occurs when in_valid && in_ready.
- Output stage is one register. Packed word appears on mem_din with mem_write=1 the cycle after acceptance (latency 1).
- mem_write, mem_addr and mem_din hold stable while mem_ready=0. After a write completes (mem_write && mem_ready), mem_addr increments and word_count increments.
- Back-to-back accepts give one write per cycle when mem_ready=1.
- Encoding, keyed on {opcode,op}; word = {opcode,op,...}:
  - 110_10 MOV imm: {Rn, imm[7:0]}. Requires -128<=imm<=127.
  - 110_00 MOV reg: {3'b000, Rd, shift, Rm}.
  - 101_00 ADD, 101_10 AND: {Rn, Rd, shift, Rm}.
  - 101_01 CMP: {Rn, 3'b000, shift, Rm}.
  - 101_11 MVN: {3'b000, Rd, shift, Rm}.
  - 011_00 LDR, 100_00 STR: {Rn, Rd, imm[4:0]}. Requires -16<=imm<=15. The shift input is ignored.
  - 111_00 HALT: 11'b0. After HALT is written, the block enters DONE. halt_pending blocks further accepts from acceptance until the write completes.
  - Any other code: illegal.
- Range check: the full 16-bit imm must equal the sign-extension of its truncated field.
- Error bundles are accepted (handshake completes), produce no write, set the sticky flag, and leave addr and word_count unchanged.
- An error on the same cycle as a valid write in the output stage does not disturb that write.
- Address wrap: on completing a write at address 2**ADDR_W-1, go to DONE and leave mem_addr at that value. No wrap-around write is ever issued.
- reset_n asserted mid-write: the write is abandoned immediately and all outputs take their reset values.

Test Plan:
- start, start_addr=0x10; then MOV R3,#-5 (110_10, rn=3, imm=0xFFFB) -> next cycle mem_write=1, mem_addr=0x10, mem_din=0xD3FB; word_count=1.
- ADD R1,R2,R4 LSL (101_00, rn=2, rd=1, shift=01, rm=4), then LDR R5,[R6,#-16] (011_00, rn=6, rd=5, imm=0xFFF0, shift=11), back-to-back with mem_ready=1 -> writes 0xA22C then 0x66B0 at consecutive addresses. The LDR shift is ignored.
- STR with imm=16 -> err_range=1, no write, mem_addr unchanged. A following valid STR imm=15 writes at the same address.
- mem_ready held 0 for 3 cycles during a write -> mem_write/mem_addr/mem_din stable and in_ready=0. Write completes on the first mem_ready=1 cycle.
- HALT (111_00) -> writes 0xE000, then done=1 and in_ready=0. A second start re-enters LOAD with word_count=0 and errors cleared.
- ADDR_W=2, start_addr=3, two MOV bundles -> one write at address 3, then done=1 and the second bundle is not accepted.
- reset_n pulsed low during a stalled write -> mem_write=0 and state IDLE immediately, asynchronously.
